// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator for a slow combinational ALU: launches registered operands,
// waits a fixed settle window, captures result/flags and re-checks the zero flag.
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CMD_W         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [CMD_W-1:0] req_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CMD_W-1:0] alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             busy,
  output logic [15:0]      op_count,
  output logic             zero_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter is loaded with SETTLE_CYCLES-1 so the capture lands SETTLE_CYCLES edges after accept.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       ref_zero;

  assign ref_zero = (alu_result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every state element uses non-blocking assignment so all registers
      // update together on the edge, independent of statement order.
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cmd      <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      op_count     <= '0;
      zero_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_cmd   <= req_cmd;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_valid    <= 1'b1;
            // Sticky: the reported flag is passed through untouched, only the error is flagged.
            if (alu_zero != ref_zero) zero_err <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle initiator that drives the combinational gate-level ALU (bitwise AND/OR/XOR datapath plus zero flag) and samples its outputs after a fixed settle window.
- The gate-level ALU has long propagation delays, so its outputs are never sampled in the cycle the operands are applied.
- Accepts operation requests on a valid/ready interface, holds operands stable, captures result and flags, and returns them on a second valid/ready interface.
- Independently re-checks the ALU zero flag against the captured result and reports mismatches.

Parameters:
WIDTH, 32, operand/result width
SETTLE_CYCLES, 4, clock edges between operand launch and result capture; legal range 1..15
CMD_W, 3, ALU command width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_cmd  input  CMD_W  ALU command
alu_a  output  WIDTH  operand A driven to ALU (registered)
alu_b  output  WIDTH  operand B driven to ALU (registered)
alu_cmd  output  CMD_W  command driven to ALU (registered)
alu_result  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry-out
alu_overflow  input  1  ALU overflow
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  captured result
rsp_zero  output  1  captured zero flag
rsp_carry  output  1  captured carry
rsp_overflow  output  1  captured overflow
busy  output  1  high in any state other than IDLE
op_count  output  16  completed-operation counter
zero_err  output  1  sticky zero-flag mismatch

Behaviour:
- Reset: every output is 0, state is IDLE, and the settle counter is 0. The exception is req_ready, which is 1 in the first cycle after reset. Reset mid-operation aborts the operation; no response is produced and op_count is not incremented.
- States: IDLE, SETTLE, RESP.
- IDLE behaviour:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_a/req_b/req_cmd into alu_a/alu_b/alu_cmd, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
  - With req_valid=0, stay in IDLE. alu_* hold their last values.
- SETTLE behaviour:
  - req_ready=0 and busy=1.
  - If the counter is nonzero, decrement it.
  - If the counter is zero, capture alu_result/alu_zero/alu_carry/alu_overflow into the rsp_* registers, set rsp_valid=1, and go to RESP.
  - The capture edge is exactly SETTLE_CYCLES edges after the accept edge.
- RESP behaviour:
  - rsp_valid=1. rsp_* and alu_* are held stable until the handshake.
  - On an edge with rsp_ready=1: clear rsp_valid, increment op_count, and go to IDLE.
  - No request is accepted in the handshake cycle, so the minimum accept-to-accept spacing is SETTLE_CYCLES+2 edges.
- Operand stability: alu_a/alu_b/alu_cmd change only on an accept edge or on reset. Request inputs are ignored outside IDLE.
- Zero check: at the capture edge, compute ref_zero = (alu_result == 0). If alu_zero != ref_zero, set zero_err. zero_err is cleared only by reset. rsp_zero always carries alu_zero as sampled; it is never corrected.
- op_count wraps from 16'hFFFF to 0.
- rsp_ready held high before rsp_valid has no effect.
- req_valid held high through SETTLE/RESP is not accepted until the next IDLE cycle.
- SETTLE_CYCLES=1: capture occurs on the edge immediately after accept.

Test Plan:
- Reset, then an AND request with a=32'hF0F0_1234, b=32'h0FF0_FFFF, ALU model result 32'h00F0_1234 with zero=0. Required: rsp_valid rises exactly 4 edges after the accept edge, rsp_result=32'h00F0_1234, rsp_zero=0, op_count=1, zero_err=0.
- Hold the response: rsp_ready=0 for 10 cycles after rsp_valid, and change req_* meanwhile. Required: rsp_* and alu_* stay constant, req_ready=0; with rsp_ready=1, op_count increments once and req_ready=1 the next cycle.
- Zero mismatch: ALU model returns result 0 with alu_zero=0. Required: zero_err=1 after the capture edge and remains 1 across 3 later good operations; cleared only by reset.
- Back-to-back: req_valid held high with rsp_ready=1 for 3 requests. Required: accept edges spaced exactly 6 edges apart (SETTLE_CYCLES=4) and op_count=3.
- Reset mid-operation: reset asserted 2 edges after accept. Required: the next cycle shows state IDLE, rsp_valid=0, op_count=0, alu_a=0, and no response ever appears.
- Counter wrap: preload the bench to 65535 completions, or force op_count to 16'hFFFF, then complete one operation. Required: op_count=0.
